// File: rtl/fb_scanout.sv
// VGA scanout: raster counters, per-pixel framebuffer reads, and sync/blank alignment across the read latency.
// Optional: define FB_DOUBLE_BUFFER_EN to latch buf_sel once per frame and drive fb_rd_buf from it.
module fb_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int RD_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] fb_rd_x,
    output logic [9:0] fb_rd_y,
    output logic       fb_re,
    output logic       fb_rd_buf,
    input  logic [3:0] fb_rd_data,
    input  logic       buf_sel,
    output logic       hsync,
    output logic       vsync,
    output logic       blank,
    output logic [3:0] pixel,
    output logic       frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } align_t;

    localparam align_t IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, blank: 1'b1};

    logic [9:0] h_cnt, v_cnt;
    logic       active;
    align_t     raw;
    align_t     pipe [RD_LATENCY];

    // NOTE: sequential state is updated with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // NOTE: continuous assigns cannot infer latches; every combinational output is fully specified here.
    assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign fb_re      = active && !reset;
    assign fb_rd_x    = fb_re ? h_cnt : 10'd0;
    assign fb_rd_y    = fb_re ? v_cnt : 10'd0;
    assign frame_done = !reset && (h_cnt == 10'd0) && (v_cnt == V_ACT);

    assign raw.hs    = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign raw.vs    = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign raw.blank = ~active;

    // NOTE: the alignment stages are reset explicitly; their idle value is what the monitor sees after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= IDLE;
        end else begin
            pipe[0] <= raw;
            for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // The last stage lines up with the RAM return, so the data is masked by that stage's blank.
    assign hsync = pipe[RD_LATENCY-1].hs;
    assign vsync = pipe[RD_LATENCY-1].vs;
    assign blank = pipe[RD_LATENCY-1].blank;
    assign pixel = blank ? 4'h0 : fb_rd_data;

`ifdef FB_DOUBLE_BUFFER_EN
    logic disp_buf;

    // Sampled on the final clock of a frame so the displayed buffer never switches mid-frame.
    always_ff @(posedge clk) begin
        if (reset)
            disp_buf <= 1'b0;
        else if ((h_cnt == H_LAST) && (v_cnt == V_LAST))
            disp_buf <= buf_sel;
    end

    assign fb_rd_buf = disp_buf && !reset;
`else
    logic unused_buf_sel;
    assign unused_buf_sel = buf_sel;
    assign fb_rd_buf      = 1'b0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// Randomized bench for fb_scanout: three instances (small timings with latency 1 and 3, default timing)
// checked every clock against a position-based reference model driven by a small emulated RAM.
module tb_fb_scanout;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit pol;
        int lat;
    } cfg_t;

    typedef struct packed {
        logic       re;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic [3:0] pix;
        logic       fd;
    } exp_t;

    typedef struct packed {
        logic       re;
        logic [9:0] x;
        logic [9:0] y;
    } addr_t;

    localparam cfg_t CS1 = '{ha: 16, hf: 2, hs: 3, hb: 4, va: 6, vf: 2, vs: 2, vb: 3, pol: 1'b0, lat: 1};
    localparam cfg_t CS3 = '{ha: 16, hf: 2, hs: 3, hb: 4, va: 6, vf: 2, vs: 2, vb: 3, pol: 1'b1, lat: 3};
    localparam cfg_t CD  = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0, lat: 2};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic buf_sel = 1'b0;

    logic [9:0] x_s1, y_s1, x_s3, y_s3, x_d, y_d;
    logic       re_s1, re_s3, re_d, rb_s1, rb_s3, rb_d;
    logic [3:0] data_s1 = 4'h0, data_s3 = 4'h0, data_d = 4'h0;
    logic [3:0] pix_s1, pix_s3, pix_d;
    logic       hs_s1, vs_s1, bl_s1, fd_s1;
    logic       hs_s3, vs_s3, bl_s3, fd_s3;
    logic       hs_d, vs_d, bl_d, fd_d;

    int  n_checks = 0;
    int  n_fail = 0;
    int  pos = 0;
    bit  known = 1'b0;
    bit  disp_s = 1'b0;
    bit  disp_d = 1'b0;
    int  seed;
    addr_t hist_s1[$], hist_s3[$], hist_d[$];

    always #5 clk = ~clk;

    fb_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2),
                 .V_BP(3), .SYNC_POL(1'b0), .RD_LATENCY(1)) u_s1 (
        .clk(clk), .reset(reset), .fb_rd_x(x_s1), .fb_rd_y(y_s1), .fb_re(re_s1), .fb_rd_buf(rb_s1),
        .fb_rd_data(data_s1), .buf_sel(buf_sel), .hsync(hs_s1), .vsync(vs_s1), .blank(bl_s1),
        .pixel(pix_s1), .frame_done(fd_s1));

    fb_scanout #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4), .V_ACTIVE(6), .V_FP(2), .V_SYNC(2),
                 .V_BP(3), .SYNC_POL(1'b1), .RD_LATENCY(3)) u_s3 (
        .clk(clk), .reset(reset), .fb_rd_x(x_s3), .fb_rd_y(y_s3), .fb_re(re_s3), .fb_rd_buf(rb_s3),
        .fb_rd_data(data_s3), .buf_sel(buf_sel), .hsync(hs_s3), .vsync(vs_s3), .blank(bl_s3),
        .pixel(pix_s3), .frame_done(fd_s3));

    fb_scanout u_d (
        .clk(clk), .reset(reset), .fb_rd_x(x_d), .fb_rd_y(y_d), .fb_re(re_d), .fb_rd_buf(rb_d),
        .fb_rd_data(data_d), .buf_sel(buf_sel), .hsync(hs_d), .vsync(vs_d), .blank(bl_d),
        .pixel(pix_d), .frame_done(fd_d));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (pos=%0d reset=%0b t=%0t)", tag, obs, exp, pos, reset, $time);
        end
    endtask

    // Framebuffer contents as seen by the display: a seeded function of the pixel coordinates.
    function automatic logic [3:0] pix_val(input int x, input int y);
        return 4'(x + 3 * y + (x >> 4) * 5 + seed);
    endfunction

    // Expected outputs for raster position `p` clocks after the last reset edge.
    function automatic exp_t model(input cfg_t c, input int p, input bit rst);
        exp_t e;
        int ht, vt, h, v, q, hq, vq;
        bit act;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        h   = p % ht;
        v   = (p / ht) % vt;
        act = (h < c.ha) && (v < c.va);
        e.re = act && !rst;
        e.x  = e.re ? 10'(h) : 10'd0;
        e.y  = e.re ? 10'(v) : 10'd0;
        e.fd = !rst && (h == 0) && (v == c.va);
        if (p < c.lat) begin
            e.hs  = ~c.pol;
            e.vs  = ~c.pol;
            e.bl  = 1'b1;
            e.pix = 4'h0;
        end else begin
            q  = p - c.lat;
            hq = q % ht;
            vq = (q / ht) % vt;
            e.bl  = !((hq < c.ha) && (vq < c.va));
            e.hs  = (hq >= c.ha + c.hf && hq < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
            e.vs  = (vq >= c.va + c.vf && vq < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
            e.pix = e.bl ? 4'h0 : pix_val(hq, vq);
        end
        return e;
    endfunction

    function automatic bit is_last(input cfg_t c, input int p);
        int ht, vt;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        return ((p % ht) == ht - 1) && (((p / ht) % vt) == vt - 1);
    endfunction

    // Emulated RAM: returns the data for the address issued `lat` clocks ago, garbage if not a read.
    function automatic logic [3:0] ram_data(input addr_t q[$], input int lat);
        if (q.size() >= lat && q[lat-1].re)
            return pix_val(int'(q[lat-1].x), int'(q[lat-1].y));
        return 4'($urandom);
    endfunction

    task automatic check_inst(input string nm, input exp_t e, input logic re, input logic [9:0] x,
                              input logic [9:0] y, input logic hs, input logic vs, input logic bl,
                              input logic [3:0] pix, input logic fd, input logic rb, input logic erb);
        check({nm, ".fb_re"}, 32'(re), 32'(e.re));
        check({nm, ".fb_rd_x"}, 32'(x), 32'(e.x));
        check({nm, ".fb_rd_y"}, 32'(y), 32'(e.y));
        check({nm, ".hsync"}, 32'(hs), 32'(e.hs));
        check({nm, ".vsync"}, 32'(vs), 32'(e.vs));
        check({nm, ".blank"}, 32'(bl), 32'(e.bl));
        check({nm, ".pixel"}, 32'(pix), 32'(e.pix));
        check({nm, ".frame_done"}, 32'(fd), 32'(e.fd));
        check({nm, ".fb_rd_buf"}, 32'(rb), 32'(erb));
    endtask

    // One pixel clock: advance the model past the edge, feed RAM data, apply next inputs, check.
    task automatic cycle(input bit next_rst);
        logic erb_s, erb_d;
        @(negedge clk);
        if (reset) begin
            pos    = 0;
            known  = 1'b1;
            disp_s = 1'b0;
            disp_d = 1'b0;
        end else if (known) begin
            if (is_last(CS1, pos)) disp_s = buf_sel;
            if (is_last(CD, pos)) disp_d = buf_sel;
            pos++;
        end
        data_s1 = ram_data(hist_s1, CS1.lat);
        data_s3 = ram_data(hist_s3, CS3.lat);
        data_d  = ram_data(hist_d, CD.lat);
        reset = next_rst;
        if ($urandom_range(0, 99) < 2) buf_sel = ~buf_sel;
        #1;
`ifdef FB_DOUBLE_BUFFER_EN
        erb_s = reset ? 1'b0 : disp_s;
        erb_d = reset ? 1'b0 : disp_d;
`else
        erb_s = 1'b0;
        erb_d = 1'b0;
`endif
        if (known) begin
            check_inst("s1", model(CS1, pos, reset), re_s1, x_s1, y_s1, hs_s1, vs_s1, bl_s1, pix_s1, fd_s1, rb_s1, erb_s);
            check_inst("s3", model(CS3, pos, reset), re_s3, x_s3, y_s3, hs_s3, vs_s3, bl_s3, pix_s3, fd_s3, rb_s3, erb_s);
            check_inst("def", model(CD, pos, reset), re_d, x_d, y_d, hs_d, vs_d, bl_d, pix_d, fd_d, rb_d, erb_d);
        end
        hist_s1.push_front('{re: re_s1, x: x_s1, y: y_s1});
        hist_s3.push_front('{re: re_s3, x: x_s3, y: y_s3});
        hist_d.push_front('{re: re_d, x: x_d, y: y_d});
        if (hist_s1.size() > 4) void'(hist_s1.pop_back());
        if (hist_s3.size() > 4) void'(hist_s3.pop_back());
        if (hist_d.size() > 4) void'(hist_d.pop_back());
    endtask

    initial begin
        int k;
        int hold;
        seed = int'($urandom_range(0, 15));

        // Three reset clocks, released at the end of the third.
        repeat (2) cycle(1'b1);
        cycle(1'b0);

        // Run the default instance to h=300 on line 1, then reset there for two clocks.
        repeat (1099) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);

        // A full default line plus several small frames, then a reset at a random point.
        repeat (1000) cycle(1'b0);
        k    = int'($urandom_range(30, 900));
        hold = int'($urandom_range(1, 3));
        repeat (k - 1) cycle(1'b0);
        cycle(1'b1);
        repeat (hold - 1) cycle(1'b1);
        cycle(1'b0);
        repeat (400) cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
